// File: rtl/led_seq_ctrl.sv
// LED sequencer: prescaler tick-enable drives blink/sweep patterns, otherwise LEDs mirror pb.
// Optional macro LED_SEQ_PB_ABORT_EN: any pressed button aborts a running pattern.
module led_seq_ctrl #(
  parameter int unsigned TICK_DIV    = 13500000,
  parameter int unsigned BLINK_COUNT = 3,
  parameter logic [3:0]  SWEEP_KEY   = 4'b1001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dip,
  input  logic [3:0] pb,
  output logic [3:0] led,
  output logic       busy,
  output logic       tick
);

  localparam int unsigned CW         = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [3:0] PHASE_LAST  = 4'(2 * BLINK_COUNT - 1);

  typedef enum logic [2:0] {S_PASS, S_BLINK, S_UP, S_DN, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [3:0]    led_q, led_d;
  logic [3:0]    dip_q, dip_d;
  logic [3:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          restart;

  assign tick    = (cnt_q == CNT_LAST);
  assign restart = (dip != dip_q);
  assign led     = led_q;
  assign busy    = busy_q;

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    phase_d = phase_q;
    dip_d   = dip;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;

    if (restart) begin
      cnt_d = '0;
      if (dip == SWEEP_KEY) begin
        state_d = S_UP;
        led_d   = 4'b0001;
      end else begin
        state_d = S_BLINK;
        led_d   = 4'b1111;
        phase_d = 4'd0;
      end
    end else begin
      case (state_q)
        S_PASS, S_HOLD: led_d = pb;
        S_BLINK: begin
          if (tick) begin
            phase_d = phase_q + 4'd1;
            led_d   = phase_d[0] ? 4'b0000 : 4'b1111;
            // Burst exit hands the LEDs straight back to the buttons.
            if (phase_q == PHASE_LAST) begin
              state_d = S_PASS;
              led_d   = pb;
            end
          end
        end
        S_UP: begin
          if (tick) begin
            if (led_q == 4'b1000) begin
              state_d = S_DN;
              led_d   = 4'b0100;
            end else begin
              led_d = led_q << 1;
            end
          end
        end
        S_DN: begin
          if (tick) begin
            if (led_q == 4'b0000) begin
              state_d = S_HOLD;
              led_d   = pb;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        default: state_d = S_PASS;
      endcase
`ifdef LED_SEQ_PB_ABORT_EN
      if (busy_q && (pb != 4'b0000)) begin
        state_d = S_PASS;
        led_d   = pb;
      end
`else
`endif
    end

    busy_d = (state_d == S_BLINK) || (state_d == S_UP) || (state_d == S_DN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_PASS;
      led_q   <= 4'b0000;
      dip_q   <= 4'b0000;
      phase_q <= 4'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      dip_q   <= dip_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

endmodule
